// File: rtl/uart_rx_fsm_if.sv
// Serial line, frame configuration and recovered-word strobes between the
// line driver (master) and the UART receiver (slave).
interface uart_rx_fsm_if #(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE_W  = 6
);
    logic                   RX_IN;
    logic [PRESCALE_W-1:0]  PRESCALE;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [DATA_LENGTH-1:0] P_DATA;
    logic                   DATA_VALID;
    logic                   PAR_ERR;
    logic                   STP_ERR;

    modport master (
        output RX_IN,
        output PRESCALE,
        output PAR_EN,
        output PAR_TYP,
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_ERR,
        input  STP_ERR
    );

    modport slave (
        input  RX_IN,
        input  PRESCALE,
        input  PAR_EN,
        input  PAR_TYP,
        output P_DATA,
        output DATA_VALID,
        output PAR_ERR,
        output STP_ERR
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// Oversampling UART receiver: 3-point majority per bit, LSB-first data,
// optional parity, one stop bit, one-cycle result/error strobes.
module uart_rx_fsm #(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE_W  = 6
) (
    input  logic         CLK,
    input  logic         RST,
    uart_rx_fsm_if.slave bus
);
    localparam int BCW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    localparam logic [PRESCALE_W-1:0]  EC_ZERO   = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0]  EC_ONE    = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [BCW-1:0]         BC_ZERO   = {BCW{1'b0}};
    localparam logic [BCW-1:0]         BC_ONE    = {{(BCW-1){1'b0}}, 1'b1};
    localparam logic [BCW-1:0]         BC_LAST   = BCW'(DATA_LENGTH - 1);
    localparam logic [DATA_LENGTH-1:0] WORD_ZERO = {DATA_LENGTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic parity_bit(input logic [DATA_LENGTH-1:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    state_t                 state_q;
    logic [PRESCALE_W-1:0]  edge_cnt_q;
    logic [PRESCALE_W-1:0]  prescale_q;
    logic [BCW-1:0]         bit_cnt_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic [2:0]             samp_q;
    logic [DATA_LENGTH-1:0] shadow_q;
    logic [DATA_LENGTH-1:0] p_data_q;
    logic                   par_bad_q;
    logic                   data_valid_q;
    logic                   par_err_q;
    logic                   stp_err_q;

    logic [PRESCALE_W-1:0]  half_s;
    logic                   sample_s;
    logic                   bit_end_s;
    logic                   maj_s;

    // Bit-timing decode from the latched prescale: sample window and bit end.
    always_comb begin
        half_s    = prescale_q >> 1;
        sample_s  = (edge_cnt_q == (half_s - EC_ONE)) ||
                    (edge_cnt_q == half_s) ||
                    (edge_cnt_q == (half_s + EC_ONE));
        bit_end_s = (edge_cnt_q == (prescale_q - EC_ONE));
        maj_s     = majority3(samp_q);
    end

    // Receive FSM: start detect, sampling, deserialisation and end-of-frame strobes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= EC_ZERO;
            prescale_q   <= EC_ZERO;
            bit_cnt_q    <= BC_ZERO;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_q       <= 3'b000;
            shadow_q     <= WORD_ZERO;
            p_data_q     <= WORD_ZERO;
            par_bad_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            if (state_q != S_IDLE) begin
                edge_cnt_q <= bit_end_s ? EC_ZERO : (edge_cnt_q + EC_ONE);
                if (sample_s) begin
                    samp_q <= {samp_q[1:0], bus.RX_IN};
                end else begin
                    samp_q <= samp_q;
                end
            end else begin
                edge_cnt_q <= EC_ZERO;
            end

            case (state_q)
                S_IDLE: begin
                    // The detect cycle counts as edge 0 of the start bit.
                    if (!bus.RX_IN) begin
                        state_q    <= S_START;
                        edge_cnt_q <= EC_ONE;
                        bit_cnt_q  <= BC_ZERO;
                        prescale_q <= bus.PRESCALE;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        par_bad_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        state_q <= maj_s ? S_IDLE : S_DATA;
                    end else begin
                        state_q <= S_START;
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        shadow_q <= {maj_s, shadow_q[DATA_LENGTH-1:1]};
                        if (bit_cnt_q == BC_LAST) begin
                            bit_cnt_q <= BC_ZERO;
                            state_q   <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BC_ONE;
                        end
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_PARITY: begin
                    if (bit_end_s) begin
                        par_bad_q <= (maj_s != parity_bit(shadow_q, par_typ_q));
                        state_q   <= S_STOP;
                    end else begin
                        state_q <= S_PARITY;
                    end
                end
                S_STOP: begin
                    // Back in IDLE during the strobe cycle so a following start is not lost.
                    if (bit_end_s) begin
                        state_q   <= S_IDLE;
                        par_err_q <= par_bad_q;
                        stp_err_q <= ~maj_s;
                        if (!par_bad_q && maj_s) begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shadow_q;
                        end else begin
                            data_valid_q <= 1'b0;
                        end
                    end else begin
                        state_q <= S_STOP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;
endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
UART receiver, the counterpart of the team's TOP_TX serial transmitter. It oversamples the serial line RX_IN at PRESCALE clocks per bit and recovers frames in TX format: start (0), DATA_LENGTH data bits LSB-first, optional parity, one stop (1). Each recovered word is presented on P_DATA with a one-cycle DATA_VALID strobe. Framing and parity errors are flagged with one-cycle strobes. It sits between the pad/synchroniser and the consumer logic.

Parameters:
DATA_LENGTH, 8, data bits per frame
PRESCALE_W, 6, width of the PRESCALE port

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST  input  1  synchronous, active-low reset
RX_IN  input  1  serial line, already synchronised to CLK, idle high
PRESCALE  input  PRESCALE_W  clocks per bit; legal values are 8, 16 and 32
PAR_EN  input  1  1 = a parity bit is present in the frame
PAR_TYP  input  1  0 = even parity (bit = ^data), 1 = odd parity (bit = ~^data)
P_DATA  output  DATA_LENGTH  last correctly received word
DATA_VALID  output  1  one-cycle strobe: P_DATA updated by an error-free frame
PAR_ERR  output  1  one-cycle strobe: parity mismatch in the frame just ended
STP_ERR  output  1  one-cycle strobe: stop bit sampled as 0

Behaviour:
- Reset (RST=0 at a CLK edge): state=IDLE; counters=0; P_DATA=0; DATA_VALID=PAR_ERR=STP_ERR=0. Reset mid-frame discards the partial frame and raises no strobes.
- Configuration latch: PRESCALE, PAR_EN and PAR_TYP are latched when a start is detected. Changes mid-frame have no effect.
- edge_cnt: runs 0..PRESCALE-1 within each bit. bit_cnt: counts data bits 0..DATA_LENGTH-1.
- Bit sampling: RX_IN is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The bit value is the 2-of-3 majority, evaluated at edge_cnt = PRESCALE-1.
- States:
  - IDLE: if RX_IN=0, go to START with edge_cnt=1. The detect cycle is edge 0, called cycle 0 below.
  - START: at the end of the bit, majority=1 means a glitch: return to IDLE with no strobes. Majority=0: go to DATA.
  - DATA: at the end of each bit, shift the majority into P_DATA's shadow register LSB-first. After bit DATA_LENGTH-1, go to PARITY if PAR_EN=1, else STOP.
  - PARITY: at the end of the bit, compare the majority against the expected parity of the shadow register; record a mismatch.
  - STOP: at the end of the bit, record a stop error if the majority=0, then go to IDLE.
- Output strobes: N = 10 + PAR_EN frame bits. Strobes are registered and high only during cycle N*PRESCALE.
  - DATA_VALID=1 and P_DATA=shadow only if there is no parity error and no stop error.
  - PAR_ERR and STP_ERR reflect their recorded errors; both may assert together.
  - On any error, DATA_VALID stays 0 and P_DATA keeps its previous value.
- Back-to-back frames: the FSM is in IDLE during the strobe cycle. A new start seen low that cycle is accepted, giving zero dead time.
- Line held low (break): the frame completes with STP_ERR, then an immediate new start is detected if RX_IN is still 0.
- P_DATA holds its value between frames. DATA_VALID, PAR_ERR and STP_ERR are never high for more than one consecutive cycle.
- An illegal PRESCALE value gives undefined results. The verification bench does not use illegal values.

Test Plan:
- PRESCALE=8, PAR_EN=0, 8'h7D sent (line 0,1,0,1,1,1,1,1,0,1, each bit 8 clocks) -> DATA_VALID high exactly at cycle 80, P_DATA=8'h7D, PAR_ERR=STP_ERR=0.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, 8'hAD with parity bit 1 -> DATA_VALID at cycle 176, P_DATA=8'hAD. The same frame with parity bit 0 -> PAR_ERR pulse at cycle 176, DATA_VALID=0, P_DATA unchanged.
- PRESCALE=8, PAR_EN=1, PAR_TYP=1, 8'h59 with parity bit 1 -> P_DATA=8'h59 and DATA_VALID. Then 8'h57 with stop bit forced 0 -> STP_ERR pulse only, P_DATA stays 8'h59.
- Glitch: PRESCALE=8, RX_IN low for 3 clocks then high -> no strobes, FSM back in IDLE at cycle 8. A following valid 8'hBB frame is received correctly.
- Single-sample noise: each data bit of 8'hBA has one of its three sample points inverted -> majority vote recovers P_DATA=8'hBA.
- RST driven low at the mid-point of a data bit -> all outputs 0 next edge. After release, an 8'hAA frame receives correctly. Then 50 random back-to-back even- and odd-parity frames from TOP_TX with no idle gap: all match, no error strobes.
